// File: rtl/sp3_frame_capture_if.sv
// -----------------------------------------------------------------------------
// sp3_frame_capture_if
//   32-bit AXI-Stream style readout bus used by sp3_frame_capture.
//
//   Signals:
//     m_tdata   32  stream data word
//     m_tvalid   1  data word is valid
//     m_tready   1  sink accepts the word this cycle
//     m_tlast    1  final word of the capture
//
//   Modports:
//     master  drives data/valid/last, samples ready (the capture block)
//     slave   samples data/valid/last, drives ready (DMA / testbench sink)
// -----------------------------------------------------------------------------
interface sp3_frame_capture_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/sp3_frame_capture.sv
// -----------------------------------------------------------------------------
// sp3_frame_capture
//   Snapshot / readout stage behind the SPROCKET3 dual receiver (20 MHz frame
//   domain). Once armed and triggered it stores DEPTH consecutive 234-bit
//   uplink frames of channel A and/or B into on-chip RAM, then drains them as
//   9-word records over a 32-bit AXI-Stream bus at whatever pace the sink
//   allows.
//
//   Parameters:
//     DEPTH    frames captured per trigger (power of 2, 2..1024)
//     HDR_TAG  tag placed in bits [31:24] of every record header
//
//   Ports:
//     clk20_i            20 MHz frame clock (only clock)
//     reset              synchronous, active-high reset
//     uplinkUserData_a/b 234-bit frames of channel A / B
//     uplinkrdy_a/b_i    channel chain ready flags
//     uplinkFEC_a/b_i    channel FEC-corrected flags
//     chan_sel_i         bit0 = A, bit1 = B, sampled with arm_i
//     arm_i              single-cycle arm pulse (honoured only in IDLE)
//     trigger_i          external trigger, level-sampled while ARMED
//     trig_auto_i        trigger on first nonzero selected frame
//     abort_i            abandon an ARMED / CAPTURE session
//     m_axis             stream output (master modport)
//     busy_o             high in ARMED, CAPTURE and DRAIN
//     done_o             one-cycle pulse, registered from last-word acceptance
//     skip_count_o       frames skipped (not ready) during current capture
//
//   Record: header {HDR_TAG, chan, fec, 6'b0, timestamp} then 8 data words
//   holding frame bits [31:0] .. [233:224] (last word zero-padded).
//
//   Optional feature (macro SP3_FRAME_CAPTURE_TRAILER_EN): a trailer word
//   {8'h5A, 8'h00, skip_count} follows the last record and carries m_tlast.
// -----------------------------------------------------------------------------
module sp3_frame_capture #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic                      clk20_i,
  input  logic                      reset,
  input  logic [233:0]              uplinkUserData_a,
  input  logic                      uplinkrdy_a_i,
  input  logic                      uplinkFEC_a_i,
  input  logic [233:0]              uplinkUserData_b,
  input  logic                      uplinkrdy_b_i,
  input  logic                      uplinkFEC_b_i,
  input  logic [1:0]                chan_sel_i,
  input  logic                      arm_i,
  input  logic                      trigger_i,
  input  logic                      trig_auto_i,
  input  logic                      abort_i,
  sp3_frame_capture_if.master       m_axis,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               skip_count_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = 2 + 16 + 234 + 234;
  localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // Control state
  state_t        state_q, state_d;
  logic [1:0]    chan_sel_q, chan_sel_d;
  logic [15:0]   ts_q, ts_d;
  logic [15:0]   skip_q, skip_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          done_q, done_d;

  // Drain issue pointer: entry, channel (0 = A, 1 = B), word within record
  logic [AW-1:0] rd_entry_q, rd_entry_d;
  logic          rd_chan_q, rd_chan_d;
  logic [3:0]    rd_word_q, rd_word_d;
  logic          rd_trailer_q, rd_trailer_d;
  logic          issue_done_q, issue_done_d;

  // Stage 1: word metadata travelling alongside the RAM read
  logic          s1_valid_q, s1_valid_d;
  logic          s1_chan_q, s1_chan_d;
  logic [3:0]    s1_word_q, s1_word_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_trailer_q, s1_trailer_d;

  // Stage 2: registered stream output
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  // Capture RAM
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] mem_rdata;
  logic [ENTRY_W-1:0] wr_data;
  logic               wr_en;

  logic        rdy_ok;
  logic        trig_hit;
  logic        out_ready;
  logic        s1_free;
  logic        issue;
  logic        last_chan;
  logic        last_record_word;
  logic        issue_last;
  logic        accept_last;
  logic [31:0] word_mux;

  logic [233:0] frame_sel;
  logic         fec_sel;
  logic [255:0] frame_pad;
  logic [2:0]   data_k;

  // Entry layout: {fecA, fecB, ts, frameA, frameB}
  assign wr_data = {uplinkFEC_a_i, uplinkFEC_b_i, ts_q, uplinkUserData_a, uplinkUserData_b};

  // A frame is kept only if every selected channel is ready.
  assign rdy_ok = (~chan_sel_q[0] | uplinkrdy_a_i) & (~chan_sel_q[1] | uplinkrdy_b_i);

  assign trig_hit = trigger_i |
                    (trig_auto_i & ((chan_sel_q[0] & (|uplinkUserData_a)) |
                                    (chan_sel_q[1] & (|uplinkUserData_b))));

  // Two-stage pipeline (RAM read, output register) with back-pressure.
  assign out_ready = ~out_valid_q | m_axis.m_tready;
  assign s1_free   = ~s1_valid_q | out_ready;
  assign issue     = (state_q == ST_DRAIN) & ~issue_done_q & s1_free;

  // The current record is the last of its entry when it is channel B, or when
  // only channel A is selected.
  assign last_chan        = rd_chan_q | ~chan_sel_q[1];
  assign last_record_word = (rd_word_q == 4'd8) & last_chan & (rd_entry_q == LAST_ENTRY);

`ifdef SP3_FRAME_CAPTURE_TRAILER_EN
  assign issue_last = rd_trailer_q;
`else
  assign issue_last = last_record_word;
`endif

  assign accept_last = out_valid_q & m_axis.m_tready & out_last_q;

  // FSM next-state, capture write control and drain issue pointer
  always_comb begin
    state_d      = state_q;
    chan_sel_d   = chan_sel_q;
    ts_d         = ts_q;
    skip_d       = skip_q;
    wr_ptr_d     = wr_ptr_q;
    done_d       = 1'b0;
    rd_entry_d   = rd_entry_q;
    rd_chan_d    = rd_chan_q;
    rd_word_d    = rd_word_q;
    rd_trailer_d = rd_trailer_q;
    issue_done_d = issue_done_q;
    wr_en        = 1'b0;

    if (state_q != ST_IDLE) begin
      ts_d = ts_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_i && (chan_sel_i != 2'b00)) begin
          state_d    = ST_ARMED;
          chan_sel_d = chan_sel_i;
          ts_d       = 16'd0;
          skip_d     = 16'd0;
          wr_ptr_d   = '0;
        end
      end

      ST_ARMED: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (trig_hit) begin
          // The trigger frame is stored as entry 0 regardless of ready.
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          state_d  = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (rdy_ok) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == LAST_ENTRY) begin
            state_d      = ST_DRAIN;
            rd_entry_d   = '0;
            rd_chan_d    = ~chan_sel_q[0];
            rd_word_d    = 4'd0;
            rd_trailer_d = 1'b0;
            issue_done_d = 1'b0;
          end
        end else if (skip_q != 16'hFFFF) begin
          skip_d = skip_q + 16'd1;
        end
      end

      ST_DRAIN: begin
        if (issue) begin
          if (rd_trailer_q) begin
            issue_done_d = 1'b1;
          end else if (rd_word_q == 4'd8) begin
            rd_word_d = 4'd0;
            if (!last_chan) begin
              rd_chan_d = 1'b1;
            end else begin
              rd_chan_d = ~chan_sel_q[0];
              if (rd_entry_q == LAST_ENTRY) begin
`ifdef SP3_FRAME_CAPTURE_TRAILER_EN
                rd_trailer_d = 1'b1;
`else
                issue_done_d = 1'b1;
`endif
              end else begin
                rd_entry_d = rd_entry_q + AW'(1);
              end
            end
          end else begin
            rd_word_d = rd_word_q + 4'd1;
          end
        end
        if (accept_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Select the word for stage 2 from the entry read out of RAM
  always_comb begin
    frame_sel = s1_chan_q ? mem_rdata[233:0] : mem_rdata[467:234];
    fec_sel   = s1_chan_q ? mem_rdata[484]   : mem_rdata[485];
    frame_pad = {22'd0, frame_sel};
    // Record word 1..8 holds frame slice 0..7; word 8 wraps to slice 7.
    data_k    = s1_word_q[2:0] - 3'd1;
    if (s1_trailer_q) begin
      word_mux = {8'h5A, 8'h00, skip_q};
    end else if (s1_word_q == 4'd0) begin
      word_mux = {HDR_TAG, s1_chan_q, fec_sel, 6'd0, mem_rdata[483:468]};
    end else begin
      word_mux = frame_pad[{data_k, 5'd0} +: 32];
    end
  end

  // Pipeline advance
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_chan_d    = s1_chan_q;
    s1_word_d    = s1_word_q;
    s1_last_d    = s1_last_q;
    s1_trailer_d = s1_trailer_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    if (s1_free) begin
      s1_valid_d   = issue;
      s1_chan_d    = rd_chan_q;
      s1_word_d    = rd_word_q;
      s1_last_d    = issue_last;
      s1_trailer_d = rd_trailer_q;
    end

    if (out_ready) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        out_data_d = word_mux;
      end
    end
  end

  // Capture RAM: one write port, one registered read port (1-cycle latency)
  always_ff @(posedge clk20_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
    if (issue) begin
      mem_rdata <= mem[rd_entry_q];
    end
  end

  always_ff @(posedge clk20_i) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      chan_sel_q   <= 2'b00;
      ts_q         <= 16'd0;
      skip_q       <= 16'd0;
      wr_ptr_q     <= '0;
      done_q       <= 1'b0;
      rd_entry_q   <= '0;
      rd_chan_q    <= 1'b0;
      rd_word_q    <= 4'd0;
      rd_trailer_q <= 1'b0;
      issue_done_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_chan_q    <= 1'b0;
      s1_word_q    <= 4'd0;
      s1_last_q    <= 1'b0;
      s1_trailer_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'd0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_sel_q   <= chan_sel_d;
      ts_q         <= ts_d;
      skip_q       <= skip_d;
      wr_ptr_q     <= wr_ptr_d;
      done_q       <= done_d;
      rd_entry_q   <= rd_entry_d;
      rd_chan_q    <= rd_chan_d;
      rd_word_q    <= rd_word_d;
      rd_trailer_q <= rd_trailer_d;
      issue_done_q <= issue_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_chan_q    <= s1_chan_d;
      s1_word_q    <= s1_word_d;
      s1_last_q    <= s1_last_d;
      s1_trailer_q <= s1_trailer_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign m_axis.m_tdata  = out_data_q;
  assign m_axis.m_tvalid = out_valid_q;
  assign m_axis.m_tlast  = out_last_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign skip_count_o    = skip_q;

endmodule

// File: tb/tb_sp3_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_sp3_frame_capture
//   Self-checking bench for sp3_frame_capture. Each capture session is
//   generated here; the expected record stream is derived from the captured
//   frames, and the DUT output is compared word by word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sp3_frame_capture;

  localparam int         DEPTH   = 16;
  localparam logic [7:0] HDR_TAG = 8'hA5;

  logic         clk20_i = 1'b0;
  logic         reset;
  logic [233:0] data_a, data_b;
  logic         rdy_a, rdy_b, fec_a, fec_b;
  logic [1:0]   chan_sel;
  logic         arm, trigger, trig_auto, abort_in;
  logic         busy, done;
  logic [15:0]  skip_count;

  sp3_frame_capture_if axis_if ();

  sp3_frame_capture #(.DEPTH(DEPTH), .HDR_TAG(HDR_TAG)) dut (
    .clk20_i          (clk20_i),
    .reset            (reset),
    .uplinkUserData_a (data_a),
    .uplinkrdy_a_i    (rdy_a),
    .uplinkFEC_a_i    (fec_a),
    .uplinkUserData_b (data_b),
    .uplinkrdy_b_i    (rdy_b),
    .uplinkFEC_b_i    (fec_b),
    .chan_sel_i       (chan_sel),
    .arm_i            (arm),
    .trigger_i        (trigger),
    .trig_auto_i      (trig_auto),
    .abort_i          (abort_in),
    .m_axis           (axis_if),
    .busy_o           (busy),
    .done_o           (done),
    .skip_count_o     (skip_count)
  );

  always #25 clk20_i = ~clk20_i;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model contents of one capture
  logic [233:0] ent_a  [DEPTH];
  logic [233:0] ent_b  [DEPTH];
  logic         ent_fa [DEPTH];
  logic         ent_fb [DEPTH];
  logic [15:0]  ent_ts [DEPTH];
  logic [1:0]   model_sel;
  logic [15:0]  model_skips;
  logic [31:0]  exp_words [$];
  int           frame_ctr = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [233:0] rand_frame();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom();
    return t[233:0];
  endfunction

  task automatic drive_frames(input bit inc_frames);
    if (inc_frames) begin
      data_a = 234'(frame_ctr);
      data_b = 234'(frame_ctr + 1000);
      frame_ctr++;
    end else begin
      data_a = rand_frame();
      data_b = rand_frame();
    end
    fec_a = 1'($urandom_range(0, 1));
    fec_b = 1'($urandom_range(0, 1));
  endtask

  task automatic record_entry(input int idx, input logic [15:0] ts);
    ent_a[idx]  = data_a;
    ent_b[idx]  = data_b;
    ent_fa[idx] = fec_a;
    ent_fb[idx] = fec_b;
    ent_ts[idx] = ts;
  endtask

  // Expected stream: per entry, an A record then a B record for selected channels
  task automatic buildExpected();
    logic [255:0] padded;
    logic         fec;
    exp_words.delete();
    for (int e = 0; e < DEPTH; e++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (model_sel[ch]) begin
          padded = {22'd0, (ch == 1) ? ent_b[e] : ent_a[e]};
          fec    = (ch == 1) ? ent_fb[e] : ent_fa[e];
          exp_words.push_back({HDR_TAG, 1'(ch), fec, 6'd0, ent_ts[e]});
          for (int k = 0; k < 8; k++) exp_words.push_back(padded[32*k +: 32]);
        end
      end
    end
`ifdef SP3_FRAME_CAPTURE_TRAILER_EN
    exp_words.push_back({8'h5A, 8'h00, model_skips});
`endif
  endtask

  // Arm, wait, trigger and capture DEPTH entries; returns at the first DRAIN cycle.
  task automatic applyStimulus(input logic [1:0] sel, input int trig_delay, input bit use_auto,
                               input bit inc_frames, input int skip_start, input int skip_len,
                               input bit random_rdy);
    int          n_entries;
    int          c;
    logic [15:0] ts;
    model_sel   = sel;
    model_skips = 16'd0;
    n_entries   = 0;
    axis_if.m_tready = 1'b0;
    @(negedge clk20_i);
    arm = 1'b1; chan_sel = sel; trigger = 1'b0; trig_auto = use_auto;
    @(negedge clk20_i);
    arm = 1'b0; chan_sel = 2'b00;
    checkOutput("busy_armed", 64'(busy), 64'd1);
    ts = 16'd0;
    for (int i = 0; i < trig_delay; i++) begin
      drive_frames(inc_frames);
      if (use_auto) begin
        if (sel[0]) data_a = '0;
        if (sel[1]) data_b = '0;
      end
      rdy_a = 1'($urandom_range(0, 1));
      rdy_b = 1'($urandom_range(0, 1));
      @(negedge clk20_i);
      ts++;
    end
    drive_frames(inc_frames);
    if (use_auto) begin
      if (sel[0]) data_a = 234'd1;
      if (sel[1]) data_b = sel[0] ? 234'd0 : 234'd1;
      trigger = 1'b0;
    end else begin
      trigger = 1'b1;
    end
    rdy_a = 1'($urandom_range(0, 1));
    rdy_b = 1'($urandom_range(0, 1));
    record_entry(0, ts);
    n_entries = 1;
    @(negedge clk20_i);
    ts++;
    trigger = 1'b0;
    c = 0;
    while (n_entries < DEPTH) begin
      drive_frames(inc_frames);
      rdy_a = random_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy_b = random_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c >= skip_start && c < skip_start + skip_len) rdy_b = 1'b0;
      if ((!sel[0] || rdy_a) && (!sel[1] || rdy_b)) begin
        record_entry(n_entries, ts);
        n_entries++;
      end else begin
        model_skips++;
      end
      @(negedge clk20_i);
      ts++;
      c++;
    end
    rdy_a = 1'b0; rdy_b = 1'b0; trig_auto = 1'b0;
    buildExpected();
  endtask

  // Drain and compare; reset_at_word >= 0 asserts reset after that many accepted words.
  task automatic drainAndCheck(input bit rand_ready, input int reset_at_word);
    int          widx = 0, k = 0, first_valid = -1, budget;
    bit          stalled = 0, finished = 0;
    logic [31:0] held_data;
    logic        held_last;
    budget = exp_words.size() * 4 + 50;
    checkOutput("skip_count", 64'(skip_count), 64'(model_skips));
    while (!finished && k < budget) begin
      if (stalled) begin
        checkOutput("hold_valid", 64'(axis_if.m_tvalid), 64'd1);
        checkOutput("hold_data", 64'(axis_if.m_tdata), 64'(held_data));
        checkOutput("hold_last", 64'(axis_if.m_tlast), 64'(held_last));
      end
      if (axis_if.m_tvalid && first_valid < 0) first_valid = k;
      arm      = (k == 5);
      chan_sel = 2'b11;
      abort_in = (k == 6);
      axis_if.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (reset_at_word >= 0 && widx == reset_at_word) begin
        reset = 1'b1;
        @(negedge clk20_i);
        reset = 1'b0; arm = 1'b0; abort_in = 1'b0;
        checkOutput("reset_tvalid", 64'(axis_if.m_tvalid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        return;
      end
      if (axis_if.m_tvalid && axis_if.m_tready) begin
        checkOutput($sformatf("word%0d", widx), 64'(axis_if.m_tdata), 64'(exp_words[widx]));
        checkOutput($sformatf("last%0d", widx), 64'(axis_if.m_tlast), 64'(widx == exp_words.size() - 1));
        widx++;
        if (widx == exp_words.size()) finished = 1;
      end
      stalled   = axis_if.m_tvalid && !axis_if.m_tready;
      held_data = axis_if.m_tdata;
      held_last = axis_if.m_tlast;
      @(negedge clk20_i);
      k++;
    end
    arm = 1'b0; abort_in = 1'b0;
    if (!finished) checkOutput("drain_timeout", 64'(widx), 64'(exp_words.size()));
    checkOutput("first_valid_cycle", 64'(first_valid), 64'd2);
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("tvalid_after_done", 64'(axis_if.m_tvalid), 64'd0);
    @(negedge clk20_i);
    checkOutput("done_single", 64'(done), 64'd0);
  endtask

  initial begin
    #(50 * 90000);
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    reset = 1'b1;
    data_a = '0; data_b = '0; rdy_a = 0; rdy_b = 0; fec_a = 0; fec_b = 0;
    chan_sel = 2'b00; arm = 0; trigger = 0; trig_auto = 0; abort_in = 0;
    axis_if.m_tready = 1'b0;
    repeat (3) @(negedge clk20_i);
    checkOutput("rst_tvalid", 64'(axis_if.m_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(axis_if.m_tdata), 64'd0);
    checkOutput("rst_tlast", 64'(axis_if.m_tlast), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_skip", 64'(skip_count), 64'd0);
    reset = 1'b0;

    @(negedge clk20_i);
    arm = 1'b1; chan_sel = 2'b00;
    @(negedge clk20_i);
    arm = 1'b0;
    checkOutput("arm_sel0_ignored", 64'(busy), 64'd0);

    $display("[TB] channel A only, external trigger, incrementing frames");
    applyStimulus(2'b01, 3, 0, 1, 0, 0, 0);
    drainAndCheck(0, -1);

    $display("[TB] both channels");
    applyStimulus(2'b11, 0, 0, 0, 0, 0, 0);
    drainAndCheck(0, -1);

    $display("[TB] both channels, B not ready for 3 frames");
    applyStimulus(2'b11, 2, 0, 0, 5, 3, 0);
    drainAndCheck(0, -1);

    $display("[TB] channel A only, random ready");
    frame_ctr = 0;
    applyStimulus(2'b01, 3, 0, 1, 0, 0, 0);
    drainAndCheck(1, -1);

    $display("[TB] abort in ARMED and CAPTURE");
    @(negedge clk20_i);
    arm = 1'b1; chan_sel = 2'b10;
    @(negedge clk20_i);
    arm = 1'b0; abort_in = 1'b1; trigger = 1'b1;
    @(negedge clk20_i);
    abort_in = 1'b0; trigger = 1'b0;
    checkOutput("abort_armed_busy", 64'(busy), 64'd0);
    arm = 1'b1; chan_sel = 2'b01;
    @(negedge clk20_i);
    arm = 1'b0; trigger = 1'b1; rdy_a = 1'b1; data_a = rand_frame();
    @(negedge clk20_i);
    trigger = 1'b0;
    repeat (3) @(negedge clk20_i);
    abort_in = 1'b1;
    @(negedge clk20_i);
    abort_in = 1'b0;
    checkOutput("abort_capture_busy", 64'(busy), 64'd0);
    bad = 0;
    repeat (3 * DEPTH) begin
      @(negedge clk20_i);
      if (axis_if.m_tvalid || busy) bad++;
    end
    checkOutput("abort_no_output", 64'(bad), 64'd0);
    rdy_a = 1'b0;

    $display("[TB] reset mid-drain then clean re-capture");
    applyStimulus(2'b11, 1, 0, 0, 0, 0, 0);
    drainAndCheck(0, 50);
    applyStimulus(2'b10, 1, 0, 0, 0, 0, 1);
    drainAndCheck(0, -1);

    $display("[TB] auto trigger after 10 zero frames");
    applyStimulus(2'b01, 10, 1, 0, 0, 0, 0);
    checkOutput("auto_entry0", 64'(ent_a[0]), 64'd1);
    drainAndCheck(0, -1);

    $display("[TB] randomized sessions");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(2'($urandom_range(1, 3)), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                    0, 0, 0, 1);
      drainAndCheck(1, -1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sp3_frame_capture.md
Name: sp3_frame_capture

Overview:
- Snapshot/readout stage directly downstream of the SPROCKET3 dual receiver, in the 20 MHz frame domain.
- Once armed and triggered, it captures DEPTH consecutive 234-bit uplink frames from channel A and/or channel B into on-chip RAM.
- It then drains the captured frames as a 32-bit AXI-Stream record sequence for DMA/readout, which is far slower than the frame rate.

Parameters:
- DEPTH, 16, frames captured per trigger (power of 2, 2..1024).
- HDR_TAG, 8'hA5, tag in bits [31:24] of every record header word.

Ports:
- clk20_i  in  1  20 MHz frame clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- uplinkUserData_a  in  234  channel A frame (EC/IC in [233:230]).
- uplinkrdy_a_i  in  1  channel A chain ready.
- uplinkFEC_a_i  in  1  channel A FEC-corrected flag.
- uplinkUserData_b  in  234  channel B frame.
- uplinkrdy_b_i  in  1  channel B chain ready.
- uplinkFEC_b_i  in  1  channel B FEC flag.
- chan_sel_i  in  2  bit0 = A, bit1 = B; sampled at arm.
- arm_i  in  1  single-cycle arm pulse.
- trigger_i  in  1  external trigger, level-sampled while ARMED.
- trig_auto_i  in  1  1 = trigger on the first nonzero frame of any selected channel.
- abort_i  in  1  abort capture.
- m_tdata  out  32  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last word of the capture.
- busy_o  out  1  high in ARMED, CAPTURE and DRAIN.
- done_o  out  1  single-cycle pulse when the last word is accepted.
- skip_count_o  out  16  frames skipped during the current capture.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset in any state, including mid-drain, drops m_tvalid on the next edge. Stale RAM contents are never emitted.
- FSM states: IDLE -> ARMED -> CAPTURE -> DRAIN -> IDLE.
- IDLE:
  - arm_i with chan_sel_i != 0 latches chan_sel, clears skip_count and the 16-bit frame counter, then goes to ARMED.
  - arm_i with chan_sel_i == 0 is ignored.
- Frame counter: increments every cycle from ARMED onward and wraps 0xFFFF -> 0.
- ARMED: a trigger occurs when trigger_i = 1, or when trig_auto_i = 1 and any selected frame is nonzero. The frame present in the trigger cycle is written as entry 0 and the FSM enters CAPTURE.
- CAPTURE:
  - Each cycle, if every selected channel has rdy = 1, write {fecA, fecB, ts, frameA, frameB} at the write pointer and advance it.
  - Otherwise skip the frame and increment skip_count, saturating at 0xFFFF.
  - After entry DEPTH-1 is written, go to DRAIN on the next cycle.
- Abort: abort_i in ARMED or CAPTURE returns to IDLE in 1 cycle with no output. abort_i is ignored in DRAIN. arm_i is ignored outside IDLE.
- Drain order: for each entry in ascending order, a channel-A record (if selected), then a channel-B record (if selected).
- Record format: 9 words.
  - Header word: [31:24] = HDR_TAG, [23] = channel (0 = A, 1 = B), [22] = FEC flag, [21:16] = 0, [15:0] = timestamp.
  - Data words k = 0..7: frame[32k+31:32k]. Word 7 carries frame[233:224] in [9:0], with [31:10] = 0.
- Word count: total words = DEPTH*nch*9, where nch is 1 or 2.
- Output timing:
  - RAM read latency is 1 cycle, and the output is registered.
  - The first m_tvalid rises 2 cycles after DRAIN entry.
  - A word transfers when m_tvalid && m_tready.
  - While m_tvalid && !m_tready, m_tdata and m_tlast are held stable, and valid is never withdrawn except on reset.
  - Sustained throughput is 1 word/cycle with m_tready held at 1.
- End of drain: m_tlast is asserted on the final word only. Its acceptance pulses done_o, clears busy_o, and returns the FSM to IDLE in the same edge.

Optional Feature:
- Macro: SP3_FRAME_CAPTURE_TRAILER_EN.
- Defined: one trailer word {8'h5A, 8'h00, skip_count[15:0]} follows the last record. m_tlast moves to the trailer, so the total is DEPTH*nch*9+1 words.
- Undefined: no trailer, and m_tlast is on the last data word.

Test Plan:
1. A only, DEPTH=16, trigger_i pulse, both rdy=1, A frames = incrementing counter, m_tready=1 -> 144 words.
   - Header 0 = 0xA500_xxxx.
   - Data words match the frames.
   - m_tlast on word 143, done_o for one cycle, skip_count_o = 0.
2. Both channels, uplinkFEC_b_i = 1 -> 288 words alternating A/B records.
   - B headers have bits [23:22] = 2'b11, A headers have 2'b00.
   - Timestamps of consecutive entries differ by 1.
3. Deassert uplinkrdy_b_i for 3 cycles mid-capture -> those 3 frames are absent, skip_count_o = 3, timestamps show a gap of 4.
4. Random m_tready (50%) -> m_tdata and m_tlast are stable while stalled; the word sequence is identical to test 1.
5. abort_i in CAPTURE -> FSM in IDLE one cycle later, no m_tvalid. reset asserted at word 50 of a drain -> m_tvalid = 0 next cycle, then a re-arm yields a clean capture.
6. trig_auto_i = 1 with zero frames for 10 cycles, then frame 0x1 -> entry 0 = 0x1. With TRAILER_EN defined, the final word is 0x5A00_0000 with m_tlast.
